// File: rtl/sub1bit_half_checker_if.sv
// Vector bus between the half-subtractor path and its response checker.
// The stimulus side drives start/valid and the sampled {A, B, O, Borrow}.
interface sub1bit_half_checker_if;
  logic start;
  logic valid;
  logic A;
  logic B;
  logic O;
  logic Borrow;

  modport master (output start, valid, A, B, O, Borrow);
  modport slave  (input  start, valid, A, B, O, Borrow);
endinterface

// File: rtl/sub1bit_half_checker.sv
// Response checker for the 1-bit half subtractor: compares strobed O/Borrow
// against A-B and reports counts, input coverage and a pass/fail verdict.
module sub1bit_half_checker #(
  parameter int TOTAL_VECTORS = 8,
  parameter int COUNT_BIT     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  sub1bit_half_checker_if.slave sub,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [COUNT_BIT-1:0]  vec_count,
  output logic [COUNT_BIT-1:0]  err_count,
  output logic [3:0]            coverage,
  output logic                  err_pulse,
  output logic [3:0]            first_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [COUNT_BIT-1:0] LAST_IDX = COUNT_BIT'(TOTAL_VECTORS - 1);
  localparam logic [COUNT_BIT-1:0] ERR_MAX  = '1;

  state_t     state_reg;
  logic       exp_o;
  logic       exp_borrow;
  logic       mismatch;
  logic [1:0] ba;
  logic [3:0] cov_next;

  assign exp_o      = sub.A ^ sub.B;
  assign exp_borrow = ~sub.A & sub.B;
  assign mismatch   = (sub.O != exp_o) || (sub.Borrow != exp_borrow);
  assign ba         = {sub.B, sub.A};
  assign cov_next   = coverage | (4'b0001 << ba);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      pass      <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
      coverage  <= 4'h0;
      err_pulse <= 1'b0;
      first_err <= 4'h0;
    end else begin
      err_pulse <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          // A sample on the start edge is deliberately not checked.
          if (sub.start) begin
            state_reg <= RUN;
            pass      <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
            coverage  <= 4'h0;
            first_err <= 4'h0;
          end
        end
        RUN: begin
          if (sub.valid) begin
            vec_count <= vec_count + 1'b1;
            coverage  <= cov_next;
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (err_count != ERR_MAX)
                err_count <= err_count + 1'b1;
              if (err_count == '0)
                first_err <= {sub.A, sub.B, sub.O, sub.Borrow};
            end
            if (vec_count == LAST_IDX) begin
              state_reg <= DONE;
              pass      <= (err_count == '0) && !mismatch && (cov_next == 4'hF);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_sub1bit_half_checker.sv
// Bench for sub1bit_half_checker: table vectors, directed corner sequences,
// randomized runs against an arithmetic A-B reference, and a saturation run.
module tb_sub1bit_half_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sub1bit_half_checker_if ifa ();
  sub1bit_half_checker_if ifb ();

  logic       busy_a, done_a, pass_a, err_pulse_a;
  logic [7:0] vec_a, err_a;
  logic [3:0] cov_a, first_a;

  logic       busy_b, done_b, pass_b, err_pulse_b;
  logic [1:0] vec_b, err_b;
  logic [3:0] cov_b, first_b;

  sub1bit_half_checker #(.TOTAL_VECTORS(8), .COUNT_BIT(8)) dut_a (
    .clk(clk), .reset(reset), .sub(ifa.slave),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .vec_count(vec_a), .err_count(err_a), .coverage(cov_a),
    .err_pulse(err_pulse_a), .first_err(first_a)
  );

  sub1bit_half_checker #(.TOTAL_VECTORS(3), .COUNT_BIT(2)) dut_b (
    .clk(clk), .reset(reset), .sub(ifb.slave),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .vec_count(vec_b), .err_count(err_b), .coverage(cov_b),
    .err_pulse(err_pulse_b), .first_err(first_b)
  );

  typedef struct {
    logic [3:0] v;       // {A, B, O, Borrow}
    logic       exp_err;
  } vec_rec_t;

  typedef struct {
    int         errs;
    logic [3:0] cov;
    logic [3:0] first;
    logic       pass;
  } res_t;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] run_q[$];
  vec_rec_t   tab[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: difference and borrow come from integer subtraction A-B.
  function automatic logic [3:0] good(input logic a, input logic b);
    int d;
    d = int'(a) - int'(b);
    return {a, b, (d != 0), (d < 0)};
  endfunction

  function automatic logic is_bad(input logic [3:0] v);
    return good(v[3], v[2]) != v;
  endfunction

  function automatic res_t model(input logic [3:0] q[$], input int maxerr, input int total);
    res_t r;
    r.errs = 0; r.cov = 4'h0; r.first = 4'h0;
    foreach (q[i]) begin
      r.cov[2 * int'(q[i][2]) + int'(q[i][3])] = 1'b1;
      if (is_bad(q[i])) begin
        if (r.errs == 0) r.first = q[i];
        if (r.errs < maxerr) r.errs++;
      end
    end
    r.pass = (q.size() == total) && (r.first == 4'h0) && (r.cov == 4'hF);
    return r;
  endfunction

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_pass"}, pass_a, 0);
    check({tag, "_vec"}, vec_a, 0);
    check({tag, "_err"}, err_a, 0);
    check({tag, "_cov"}, cov_a, 0);
    check({tag, "_pulse"}, err_pulse_a, 0);
    check({tag, "_first"}, first_a, 0);
  endtask

  task automatic start_run();
    ifa.start = 1'b1;
    ifa.valid = 1'b0;
    step();
    ifa.start = 1'b0;
    run_q.delete();
    check("start_busy", busy_a, 1);
  endtask

  task automatic send(input logic [3:0] v, input bit inrun);
    ifa.valid = 1'b1;
    {ifa.A, ifa.B, ifa.O, ifa.Borrow} = v;
    step();
    ifa.valid = 1'b0;
    check("err_pulse", err_pulse_a, inrun && is_bad(v));
    if (inrun) run_q.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_run(input string tag);
    res_t r;
    r = model(run_q, 255, 8);
    check({tag, "_done"}, done_a, 1);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_vec"}, vec_a, run_q.size());
    check({tag, "_err"}, err_a, r.errs);
    check({tag, "_cov"}, cov_a, r.cov);
    check({tag, "_first"}, first_a, r.first);
    check({tag, "_pass"}, pass_a, r.pass);
  endtask

  task automatic clean_run(input string tag);
    start_run();
    for (int i = 0; i < 8; i++) send(good(i[0], i[1]), 1);
    check_run(tag);
    check({tag, "_pass_exp"}, pass_a, 1);
  endtask

  initial begin
    logic [3:0] v;
    int         pulses;

    tab[0]  = '{4'b0000, 1'b0}; tab[1]  = '{4'b0001, 1'b1};
    tab[2]  = '{4'b0010, 1'b1}; tab[3]  = '{4'b0011, 1'b1};
    tab[4]  = '{4'b0100, 1'b1}; tab[5]  = '{4'b0101, 1'b1};
    tab[6]  = '{4'b0110, 1'b1}; tab[7]  = '{4'b0111, 1'b0};
    tab[8]  = '{4'b1000, 1'b1}; tab[9]  = '{4'b1001, 1'b1};
    tab[10] = '{4'b1010, 1'b0}; tab[11] = '{4'b1011, 1'b1};
    tab[12] = '{4'b1100, 1'b0}; tab[13] = '{4'b1101, 1'b1};
    tab[14] = '{4'b1110, 1'b1}; tab[15] = '{4'b1111, 1'b1};

    reset = 1'b0;
    {ifa.start, ifa.valid, ifa.A, ifa.B, ifa.O, ifa.Borrow} = '0;
    {ifb.start, ifb.valid, ifb.A, ifb.B, ifb.O, ifb.Borrow} = '0;
    #12;
    check_reset_a("reset");
    reset = 1'b1;
    step();

    // Table vectors over all 16 {A,B,O,Borrow} combinations, two runs of 8.
    for (int r = 0; r < 2; r++) begin
      start_run();
      for (int i = 0; i < 8; i++) begin
        send(tab[8 * r + i].v, 1);
        check($sformatf("tab%0d_pulse", 8 * r + i), err_pulse_a, tab[8 * r + i].exp_err);
      end
      check_run($sformatf("tab_run%0d", r));
    end

    // Clean run; err_pulse must never rise.
    clean_run("clean");

    // Borrow forced low on A=0,B=1.
    start_run();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      v = good(i[0], i[1]);
      if (v[3:2] == 2'b01) v[0] = 1'b0;
      send(v, 1);
      if (err_pulse_a) pulses++;
    end
    check_run("fault");
    check("fault_err", err_a, 2);
    check("fault_pulses", pulses, 2);
    check("fault_first", first_a, 4'b0110);

    // Coverage hole: only {B,A}=00 and 11.
    start_run();
    for (int i = 0; i < 8; i++) send(good(i[0], i[0]), 1);
    check_run("hole");
    check("hole_cov", cov_a, 4'b1001);

    // Gaps, start mid-run, valid after done, start+valid on the same edge.
    ifa.start = 1'b1;
    ifa.valid = 1'b1;
    {ifa.A, ifa.B, ifa.O, ifa.Borrow} = 4'b1111;
    step();
    ifa.start = 1'b0;
    ifa.valid = 1'b0;
    run_q.delete();
    check("startvalid_vec", vec_a, 0);
    check("startvalid_err", err_a, 0);
    send(good(1, 0), 1);
    idle(3);
    check("gap_vec", vec_a, 1);
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    check("midstart_busy", busy_a, 1);
    check("midstart_vec", vec_a, 1);
    for (int i = 0; i < 7; i++) begin
      send(good(i[1], i[0]), 1);
      idle(i % 2);
    end
    check_run("gap");
    send(4'b1111, 0);
    send(4'b0101, 0);
    check_run("after_done");

    // Asynchronous reset after 3 vectors, then a fresh clean run.
    start_run();
    for (int i = 0; i < 3; i++) send(good(i[0], i[1]), 1);
    #1 reset = 1'b0;
    #1 check_reset_a("midreset");
    reset = 1'b1;
    step();
    check_reset_a("postreset");
    clean_run("reclean");

    // Randomized runs against the reference model.
    for (int r = 0; r < 15; r++) begin
      start_run();
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          ifa.start = 1'b1;
          step();
          ifa.start = 1'b0;
        end
        idle($urandom_range(0, 2));
        v = good(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) v = v ^ (4'b0001 << $urandom_range(0, 1));
        send(v, 1);
      end
      check_run($sformatf("rand%0d", r));
    end

    // Saturation on the 2-bit counter instance.
    ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifb.valid = 1'b1;
      {ifb.A, ifb.B, ifb.O, ifb.Borrow} = 4'b1111;
      step();
      ifb.valid = 1'b0;
      check($sformatf("sat_pulse%0d", i), err_pulse_b, 1);
    end
    check("sat_err", err_b, 3);
    check("sat_vec", vec_b, 3);
    check("sat_done", done_b, 1);
    check("sat_busy", busy_b, 0);
    check("sat_pass", pass_b, 0);
    check("sat_first", first_b, 4'hF);
    check("sat_cov", cov_b, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sub1bit_half_checker.md
# sub1bit_half_checker

Self-checking response monitor for the 1-bit half subtractor. It sits at the output end of the subtractor path, opposite the counter-based stimulus generator. It samples each {A, B, O, Borrow} vector on a strobe and compares O/Borrow against the golden model A−B. It accumulates vector, error and input-coverage statistics and reports a registered pass/fail verdict once a programmed number of vectors has been checked.

## Interface
- TOTAL_VECTORS, 8, number of strobed vectors in one check run; legal range 1 to 2^COUNT_BIT−1
- COUNT_BIT, 8, width of the vector and error counters
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  begins a run from IDLE or DONE; ignored in RUN
- valid  input  1  sample strobe; A/B/O/Borrow are checked on the clk edge where valid=1 in RUN
- A  input  1  subtractor minuend
- B  input  1  subtractor subtrahend
- O  input  1  subtractor difference under test
- Borrow  input  1  subtractor borrow under test
- busy  output  1  high in RUN
- done  output  1  high in DONE
- pass  output  1  verdict, valid while done=1
- vec_count  output  COUNT_BIT  vectors checked this run
- err_count  output  COUNT_BIT  mismatching vectors this run; saturates at all-ones
- coverage  output  4  bit {B,A} set once that input combination has been checked
- err_pulse  output  1  one-cycle pulse per mismatching vector
- first_err  output  4  {A,B,O,Borrow} of the first mismatch in this run; 4'h0 if none

## Operation
- Golden model: exp_O = A ^ B; exp_Borrow = ~A & B. A vector mismatches if O≠exp_O or Borrow≠exp_Borrow.
- States: IDLE (reset state), RUN, DONE.
- IDLE: start=1 goes to RUN. On the same edge, clear vec_count, err_count, coverage and first_err.
- RUN, on each edge with valid=1:
  - vec_count +1
  - coverage[{B,A}] set
  - on mismatch: err_count +1 (saturating), err_pulse=1 next cycle, and first_err captured if err_count was 0
- RUN: the edge that samples vector number TOTAL_VECTORS goes to DONE.
  - pass = (no mismatch over all vectors, including this one) AND (coverage including this vector == 4'hF)
- RUN: valid=0 holds all state; start=1 is ignored.
- DONE: hold all counters, coverage, first_err and pass. valid is ignored. start=1 goes to RUN with the same clearing as from IDLE.
- busy = (state==RUN); done = (state==DONE). Both are decoded from registered state with no combinational path from inputs.
- Counter width: vec_count never exceeds TOTAL_VECTORS. err_count holds at 2^COUNT_BIT−1 once reached.

## Timing
- Reset values: busy=0, done=0, pass=0, vec_count=0, err_count=0, coverage=4'h0, err_pulse=0, first_err=4'h0, state IDLE.
- Reset assertion clears everything immediately, independent of clk. This includes reset mid-RUN, where a partial run is discarded with no verdict.
- All outputs are registered. Effects of a sample at edge N are visible after edge N:
  - counters, coverage and err_pulse
  - busy=0, done=1 and pass on the last vector
- err_pulse is high for exactly one cycle per mismatching sample. Back-to-back mismatches keep it high continuously.
- start and valid on the same edge in IDLE/DONE: start is taken, the sample is ignored, and the first checked vector is on the next valid edge.
- TOTAL_VECTORS=1: a single valid edge completes the run. pass is always 0 because coverage cannot be full.
- Minimum run length is TOTAL_VECTORS+1 edges: one start edge plus TOTAL_VECTORS valid edges.

## Test plan
- Clean run: reset, start, 8 valid vectors cycling {B,A}=00,01,10,11 twice with correct O/Borrow → done=1, pass=1, vec_count=8, err_count=0, coverage=4'hF, err_pulse never high.
- Injected fault: same sequence with Borrow forced 0 on {A=0,B=1} → err_count=2, two err_pulse cycles, first_err=4'b0110, pass=0.
- Coverage hole: 8 correct vectors only on {B,A}=00 and 11 → err_count=0, coverage=4'b1001, pass=0.
- Gaps and ignored inputs:
  - valid toggled with idle cycles → vec_count advances only on valid edges
  - start pulsed mid-RUN → no effect
  - valid after DONE → counters unchanged
- Reset mid-run: assert reset after 3 vectors → all outputs return to reset values asynchronously. A new start plus 8 clean vectors gives pass=1.
- Saturation: COUNT_BIT=2, TOTAL_VECTORS=3, all three vectors wrong → err_count=3, no wrap, pass=0.
